asm_char_streamer: RTL and testbench

Upstream source stage of the assembler front end. Reads raw assembly text bytes from a text BRAM and presents a normalised character stream, one character per handshake, to the token interpreters (immediate, register and opcode interpreters) and the assembler controller. Normalisation strips comments and carriage returns and collapses whitespace. Every non-empty line is terminated with `" \n"`, so each token, including a trailing immediate, ends on a space or comma delimiter. Each character is tagged with its source line number for error reporting.

---
 rtl/asm_char_streamer.sv | 159 +++++++++++++++
 tb/tb_asm_char_streamer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/asm_char_streamer.sv
// asm_char_streamer: normalises assembly text from a BRAM into a line-tagged character stream
// Ports: clk_in/rst_in (sync, active-low); start_in + text_length_in launch a run;
// bram_addr_out/bram_data_in read the text BRAM; new_character_out/ascii_out/line_number_out
// present one character per ready_in handshake; busy_out while streaming; done_out pulses at end.
module asm_char_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH:0]   text_length_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [7:0]            bram_data_in,
  input  logic                  ready_in,
  output logic                  new_character_out,
  output logic [7:0]            ascii_out,
  output logic [15:0]           line_number_out,
  output logic                  busy_out,
  output logic                  done_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {IDLE, STREAM, COMMENT, EOL_SPACE, EOL_NL, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] len_q, addr_q, popped_q;
  logic [BRAM_LATENCY-1:0] vld_q;
  logic [7:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] occ_q, inflight;
  logic [7:0] ascii_q, ascii_d, head, emit_char;
  logic [15:0] lno_q, lno_d, line_q, line_d;
  logic out_vld_q, out_vld_d, open_q, open_d, pend_q, pend_d, last_sp_q, last_sp_d;
  logic start, issue, push, pop, emit, out_free, eot, empty;
  assign start = state_q == IDLE && start_in;
  assign busy_out = state_q != IDLE && state_q != DONE;
  assign done_out = state_q == DONE;
  assign new_character_out = out_vld_q;
  assign ascii_out = ascii_q;
  assign line_number_out = lno_q;
  assign bram_addr_out = addr_q[ADDR_WIDTH-1:0];
  assign push = vld_q[BRAM_LATENCY-1];
  assign head = fifo_q[rd_q];
  assign empty = occ_q == '0;
  assign eot = popped_q == len_q;
  assign out_free = !out_vld_q || ready_in;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
  end
  // reads still in the BRAM pipeline reserve FIFO slots so returns can never overflow
  assign issue = busy_out && addr_q < len_q &&
                 ({1'b0, occ_q} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      len_q <= '0;
      addr_q <= '0;
      popped_q <= '0;
      vld_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= BRAM_LATENCY'({vld_q, issue});
      len_q <= start ? text_length_in : len_q;
      addr_q <= start ? '0 : addr_q + (ADDR_WIDTH + 1)'(issue);
      popped_q <= start ? '0 : popped_q + (ADDR_WIDTH + 1)'(pop);
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      occ_q <= occ_q + CW'(push) - CW'(pop);
      if (push) fifo_q[wr_q] <= bram_data_in;
    end
  end
  always_comb begin
    state_d = state_q;
    out_vld_d = out_vld_q & ~ready_in;
    ascii_d = ascii_q;
    lno_d = lno_q;
    line_d = line_q;
    open_d = open_q;
    pend_d = pend_q;
    last_sp_d = last_sp_q;
    pop = 1'b0;
    emit = 1'b0;
    emit_char = 8'h20;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = text_length_in == '0 ? DONE : STREAM;
        line_d = 16'd1;
        open_d = 1'b0;
        pend_d = 1'b0;
        last_sp_d = 1'b0;
      end
      STREAM, COMMENT: if (out_free) begin
        if (eot) state_d = open_q ? EOL_SPACE : DONE;
        else if (!empty) begin
          pop = 1'b1;
          if (head == 8'h0A) begin
            state_d = open_q ? EOL_SPACE : STREAM;
            line_d = open_q ? line_q : line_q + 16'd1;
          end else if (state_q == STREAM && head != 8'h0D) begin
            if (head == 8'h20 || head == 8'h09) pend_d = pend_q | open_q;
            else if (head == "#" || head == ";") state_d = COMMENT;
            else begin
              // a pending separator goes out first; the byte stays at the FIFO head until then
              emit = 1'b1;
              emit_char = pend_q ? 8'h20 : head;
              pop = ~pend_q;
              pend_d = 1'b0;
              open_d = 1'b1;
            end
          end
        end
      end
      EOL_SPACE: if (out_free) begin
        emit = ~last_sp_q;
        state_d = EOL_NL;
      end
      EOL_NL: if (out_free) begin
        emit = 1'b1;
        emit_char = 8'h0A;
        open_d = 1'b0;
        pend_d = 1'b0;
        line_d = line_q + 16'd1;
        state_d = STREAM;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (emit) begin
      out_vld_d = 1'b1;
      ascii_d = emit_char;
      lno_d = line_q;
      last_sp_d = emit_char == 8'h20;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      out_vld_q <= 1'b0;
      ascii_q <= '0;
      lno_q <= '0;
      line_q <= '0;
      open_q <= 1'b0;
      pend_q <= 1'b0;
      last_sp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_vld_q <= out_vld_d;
      ascii_q <= ascii_d;
      lno_q <= lno_d;
      line_q <= line_d;
      open_q <= open_d;
      pend_q <= pend_d;
      last_sp_q <= last_sp_d;
    end
  end
endmodule

// File: tb/tb_asm_char_streamer.sv
// tb_asm_char_streamer: scoreboard bench comparing the stream against a line-oriented text model
module tb_asm_char_streamer;
  localparam int AW = 12;
  logic clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0, ready_in = 1'b0;
  logic new_character_out, busy_out, done_out;
  logic [AW:0] text_length_in = '0;
  logic [AW-1:0] bram_addr_out;
  logic [7:0] bram_data_in, ascii_out, d1;
  logic [15:0] line_number_out;
  logic [7:0] mem [1 << AW];
  typedef struct packed {logic [7:0] c; logic [15:0] l;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, fails = 0, mode = 0, ph = 0, tlen, r;
  bit mon_en = 0, pv = 0, pr = 0;
  logic [7:0] pc;
  logic [15:0] pl;
  string letters = "abxz1,F(";

  asm_char_streamer #(.ADDR_WIDTH(AW), .BRAM_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .text_length_in(text_length_in),
    .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in), .ready_in(ready_in),
    .new_character_out(new_character_out), .ascii_out(ascii_out),
    .line_number_out(line_number_out), .busy_out(busy_out), .done_out(done_out));

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    d1 <= mem[bram_addr_out];
    bram_data_in <= d1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    #1;
    ready_in = mode == 0 ? 1'b1 : mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
  end

  always @(negedge clk_in) begin
    if (mon_en) begin
      if (pv && !pr) begin
        chk("stall_valid", new_character_out, 1);
        chk("stall_ascii", ascii_out, pc);
        chk("stall_line", line_number_out, pl);
      end
      if (new_character_out && ready_in) begin
        if (sb.size() == 0) chk("unexpected_char", new_character_out, 0);
        else begin
          e = sb.pop_front();
          chk("ascii", ascii_out, e.c);
          chk("line", line_number_out, e.l);
        end
      end
    end
    pv = mon_en && new_character_out;
    pr = ready_in;
    pc = ascii_out;
    pl = line_number_out;
  end

  function automatic void model(input int len);
    logic [7:0] o[$];
    logic [7:0] c;
    bit cmt, sep;
    int line = 1, i = 0;
    while (i < len) begin
      o.delete();
      cmt = 0;
      sep = 0;
      while (i < len && mem[i] != 8'h0A) begin
        c = mem[i];
        i++;
        if (c == "#" || c == ";") cmt = 1;
        if (!cmt && c != 8'h0D) begin
          if (c == 8'h20 || c == 8'h09) sep = sep || o.size() > 0;
          else begin
            if (sep) o.push_back(8'h20);
            sep = 0;
            o.push_back(c);
          end
        end
      end
      i++;
      if (o.size() > 0) begin
        o.push_back(8'h20);
        o.push_back(8'h0A);
      end
      foreach (o[k]) sb.push_back(exp_t'{o[k], line[15:0]});
      line++;
    end
  endfunction

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    tlen = s.len();
  endtask

  task automatic run(input int len, input bit dbl);
    int n;
    model(len);
    @(posedge clk_in);
    #1;
    start_in = 1;
    text_length_in = (AW + 1)'(len);
    @(posedge clk_in);
    #1;
    start_in = 0;
    if (dbl) begin
      repeat (2) @(posedge clk_in);
      #1;
      start_in = 1;
      text_length_in = 1;
      @(posedge clk_in);
      #1;
      start_in = 0;
    end
    n = 0;
    while (done_out !== 1'b1 && n < len * 16 + 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("done_seen", done_out, 1);
    chk("busy_at_done", busy_out, 0);
    chk("all_chars_out", sb.size(), 0);
    sb.delete();
    @(negedge clk_in);
    chk("done_one_cycle", done_out, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_newchar", new_character_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_line", line_number_out, 0);
    chk("rst_addr", bram_addr_out, 0);
    rst_in = 1;
    mon_en = 1;
    mode = 0;
    load("li x1, x1F\n");
    run(tlen, 0);
    load("  add\t\tx2 ,x3 # cmt\n\nsub x4\n");
    run(tlen, 0);
    load("nop");
    run(tlen, 0);
    mode = 1;
    load("addi x10, x11, 0x7FF ; trailing\n  sw x1, 4(x2)\nlui  x3,\t0xABCDE");
    run(tlen, 1);
    mode = 0;
    @(posedge clk_in);
    #1;
    start_in = 1;
    text_length_in = 0;
    @(posedge clk_in);
    #1;
    start_in = 0;
    @(negedge clk_in);
    chk("len0_done", done_out, 1);
    chk("len0_nochar", new_character_out, 0);
    @(negedge clk_in);
    chk("len0_done_pulse", done_out, 0);
    mode = 1;
    load("beq x1, x2, label_far_away_target_name and more operands here\n");
    model(tlen);
    @(posedge clk_in);
    #1;
    start_in = 1;
    text_length_in = (AW + 1)'(tlen);
    @(posedge clk_in);
    #1;
    start_in = 0;
    repeat (12) @(posedge clk_in);
    #1;
    mon_en = 0;
    rst_in = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1;
    chk("midrst_newchar", new_character_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_line", line_number_out, 0);
    sb.delete();
    mon_en = 1;
    repeat (5) @(negedge clk_in);
    chk("midrst_stay_idle", busy_out, 0);
    run(tlen, 0);
    for (int t = 0; t < 20; t++) begin
      tlen = $urandom_range(1, 90);
      for (int i = 0; i < tlen; i++) begin
        r = $urandom_range(0, 15);
        mem[i] = r < 8 ? letters[r] : r < 10 ? 8'h20 : r == 10 ? 8'h09 : r == 11 ? 8'h0D :
                 r < 14 ? 8'h0A : r == 14 ? 8'h23 : 8'h3B;
      end
      mode = $urandom_range(0, 2);
      run(tlen, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", checks, fails);
    $fatal(1);
  end
endmodule
